div_tick_gen: RTL

Parametrised multi-channel frequency divider and tick generator, successor to the fixed 25-bit one-second divider. Each channel has its own runtime-loadable terminal count and produces both a 50 % duty square wave and a single-cycle tick (clock-enable). Channels can be frozen and phase-aligned from a system controller. Sits between the board clock and downstream display, scan and timing logic, which consume `tick` as an enable instead of a derived clock.

---
 rtl/div_tick_gen.sv | 73 +++++++
 1 files changed

// File: rtl/div_tick_gen.sv
// Multi-channel frequency divider: each channel produces a 50% square wave and a
// single-cycle tick enable from its own runtime-loadable terminal count.
module div_tick_gen #(
  parameter int WIDTH       = 25,
  parameter int NCH         = 2,
  parameter int DEFAULT_DIV = 25_000_000,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CW-1:0]    ch_sel,
  input  logic [WIDTH-1:0] div_in,
  output logic [NCH-1:0]   freq,
  output logic [NCH-1:0]   tick
);

  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [WIDTH-1:0] div_q [NCH];
  logic [WIDTH-1:0] div_d [NCH];
  logic [NCH-1:0]   freq_q, freq_d;
  logic [NCH-1:0]   tick_q, tick_d;

  // Equality against each channel index makes out-of-range selects match nothing.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c]  = cnt_q[c];
      div_d[c]  = div_q[c];
      freq_d[c] = freq_q[c];
      tick_d[c] = 1'b0;
      if (sync) begin
        cnt_d[c]  = '0;
        freq_d[c] = 1'b0;
      end else if (load && (ch_sel == CW'(c))) begin
        div_d[c] = div_in;
        cnt_d[c] = '0;
      end else if (en) begin
        if (cnt_q[c] == div_q[c]) begin
          cnt_d[c]  = '0;
          freq_d[c] = ~freq_q[c];
          tick_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= WIDTH'(DEFAULT_DIV);
      end
      freq_q <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
      end
      freq_q <= freq_d;
      tick_q <= tick_d;
    end
  end

  assign freq = freq_q;
  assign tick = tick_q;

endmodule
